// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage controller: performs 32-bit loads/stores on a 16-bit external SRAM as two
// half-word phases with configurable wait states, stalling the pipeline via ready.
module mem_stage_sram_ctrl #(
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        ALU_result,
   input  logic [31:0]        ST_val,
   output logic [31:0]        MEM_result,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int unsigned CntW = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StLow,
      StHigh,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       result_q, result_d;

   logic              req;
   logic              is_store;
   logic              cnt_last;
   logic [31:0]       offset;
   logic [SRAM_AW-2:0] word_addr;

   assign req       = MEM_R_EN | MEM_W_EN;
   // Both enables high is illegal and resolves to a store.
   assign is_store  = MEM_W_EN;
   assign cnt_last  = (cnt_q == CntLast);
   assign offset    = ALU_result - ADDR_BASE;
   assign word_addr = offset[SRAM_AW:2];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StLow;
               cnt_d   = '0;
            end
         end
         StLow: begin
            sram_addr = {word_addr, 1'b0};
            if (is_store) begin
               sram_dq_out = ST_val[15:0];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end
            if (cnt_last) begin
               state_d = StHigh;
               cnt_d   = '0;
               if (!is_store) begin
                  result_d[15:0] = sram_dq_in;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHigh: begin
            sram_addr = {word_addr, 1'b1};
            if (is_store) begin
               sram_dq_out = ST_val[31:16];
               sram_dq_oe  = 1'b1;
               sram_we_n   = 1'b0;
            end
            if (cnt_last) begin
               state_d = StDone;
               cnt_d   = '0;
               if (!is_store) begin
                  result_d[31:16] = sram_dq_in;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Ready is high in DONE so upstream registers advance on the DONE edge.
   assign ready      = ~req | (state_q == StDone);
   assign MEM_result = result_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench: two controllers (WAIT_CYCLES 2 and 1) with behavioural SRAMs, checked
// against a word-level reference memory and per-cycle bus expectations.
module tb_mem_stage_sram_ctrl;

   localparam int unsigned Aw    = 18;
   localparam int unsigned Words = 1 << (Aw - 1);

   typedef struct {
      bit          st;
      int unsigned wa;
      bit [31:0]   data;
      bit [31:0]   res;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r_en, w_en, sel;
   logic [31:0] alu, st;

   logic        r0, w0, r1, w1;
   logic [31:0] res0, res1;
   logic        rdy0, rdy1, oe0, oe1, wen0, wen1;
   logic [Aw-1:0] addr0, addr1;
   logic [15:0] dqo0, dqo1, dqi0, dqi1;

   logic [31:0] m_res;
   logic        m_rdy, m_oe, m_wen;
   logic [Aw-1:0] m_addr;
   logic [15:0] m_dqo;

   bit [15:0]   mem0 [0:(1<<Aw)-1];
   bit [15:0]   mem1 [0:(1<<Aw)-1];
   bit [31:0]   ref_w [int unsigned];
   bit [31:0]   last_res [2];
   exp_t        q [$];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   assign r0 = r_en & ~sel;
   assign w0 = w_en & ~sel;
   assign r1 = r_en & sel;
   assign w1 = w_en & sel;

   mem_stage_sram_ctrl #(.ADDR_BASE(1024), .SRAM_AW(Aw), .WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst_n), .MEM_R_EN(r0), .MEM_W_EN(w0), .ALU_result(alu), .ST_val(st),
      .MEM_result(res0), .ready(rdy0), .sram_addr(addr0), .sram_dq_out(dqo0),
      .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(wen0)
   );

   mem_stage_sram_ctrl #(.ADDR_BASE(1024), .SRAM_AW(Aw), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst_n), .MEM_R_EN(r1), .MEM_W_EN(w1), .ALU_result(alu), .ST_val(st),
      .MEM_result(res1), .ready(rdy1), .sram_addr(addr1), .sram_dq_out(dqo1),
      .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(wen1)
   );

   // Behavioural SRAMs: asynchronous read, write on the clock edge while we_n is low.
   always @(posedge clk) begin
      if (!wen0) mem0[addr0] <= dqo0;
      if (!wen1) mem1[addr1] <= dqo1;
   end
   assign dqi0 = mem0[addr0];
   assign dqi1 = mem1[addr1];

   assign m_res  = sel ? res1  : res0;
   assign m_rdy  = sel ? rdy1  : rdy0;
   assign m_oe   = sel ? oe1   : oe0;
   assign m_wen  = sel ? wen1  : wen0;
   assign m_addr = sel ? addr1 : addr0;
   assign m_dqo  = sel ? dqo1  : dqo0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h sel=%0d t=%0t", nm, act, exp, sel, $time);
      end
   endtask

   function automatic int unsigned word_of(input bit [31:0] a);
      return ((a - 32'd1024) >> 2) % Words;
   endfunction

   // Issue one access and wait (bounded) for ready; the monitor does the checking.
   task automatic issue(input bit s, input bit r, input bit w, input bit [31:0] a,
                        input bit [31:0] d);
      exp_t        e;
      int unsigned key;
      int          n;
      @(posedge clk);
      #1;
      sel = s; r_en = r; w_en = w; alu = a; st = d;
      e.st   = w;
      e.wa   = word_of(a);
      e.data = d;
      key    = (s ? Words : 0) + e.wa;
      if (w) ref_w[key] = d;
      else   last_res[s] = ref_w.exists(key) ? ref_w[key] : 32'h0;
      e.res = last_res[s];
      q.push_back(e);
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (m_rdy) break;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout act=0 exp=1 t=%0t", $time);
         q.delete();
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      r_en = 1'b0; w_en = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   exp_t        mon_e;
   int unsigned mon_w;
   bit          mon_hi;

   always @(negedge clk) begin
      if (!rst_n) begin
         cyc = 0;
      end else begin
         mon_w = sel ? 1 : 2;
         if ((r_en | w_en) && q.size() > 0) begin
            mon_e = q[0];
            chk("ready", m_rdy, cyc == 2 * mon_w + 1);
            if (cyc == 0 || cyc == 2 * mon_w + 1) begin
               chk("addr_idle", m_addr, 0);
               chk("we_n_idle", m_wen, 1);
            end else begin
               mon_hi = (cyc > mon_w);
               chk("addr", m_addr, mon_e.wa * 2 + mon_hi);
               chk("we_n", m_wen, !mon_e.st);
               chk("dq_oe", m_oe, mon_e.st);
               if (mon_e.st) chk("dq_out", m_dqo, mon_hi ? mon_e.data[31:16] : mon_e.data[15:0]);
            end
            if (cyc == 2 * mon_w + 1) begin
               chk("mem_result", m_res, mon_e.res);
               if (mon_e.st) begin
                  chk("sram_lo", sel ? mem1[mon_e.wa*2] : mem0[mon_e.wa*2], mon_e.data[15:0]);
                  chk("sram_hi", sel ? mem1[mon_e.wa*2+1] : mem0[mon_e.wa*2+1],
                      mon_e.data[31:16]);
               end
               void'(q.pop_front());
               cyc = 0;
            end else begin
               cyc++;
            end
         end else if (!(r_en | w_en)) begin
            chk("idle_ready", m_rdy, 1);
            chk("idle_addr", m_addr, 0);
            chk("idle_we_n", m_wen, 1);
            chk("idle_oe", m_oe, 0);
            chk("idle_result", m_res, last_res[sel]);
            cyc = 0;
         end
      end
   end

   bit [31:0]   a, d, old;
   int unsigned key;
   bit          op;

   initial begin
      rst_n = 1'b0; r_en = 1'b0; w_en = 1'b0; sel = 1'b0; alu = '0; st = '0;
      last_res[0] = 0; last_res[1] = 0;
      #12;
      chk("rst_ready", rdy0, 1);
      chk("rst_result", res0, 0);
      chk("rst_we_n", wen0, 1);
      chk("rst_oe", oe0, 0);
      chk("rst_addr", addr0, 0);
      chk("rst_dq_out", dqo0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      issue(0, 0, 1, 1032, 32'hDEADBEEF);
      idle(1);
      issue(0, 1, 0, 1032, 32'h0);
      idle(10);

      // Reset asserted during the HIGH phase of a store: only the low half reaches SRAM.
      @(posedge clk);
      #1;
      sel = 0; r_en = 0; w_en = 1; alu = 1024 + 24; st = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #2;
      chk("mid_high_addr", addr0, word_of(1024 + 24) * 2 + 1);
      rst_n = 1'b0;
      #1;
      chk("arst_we_n", wen0, 1);
      chk("arst_oe", oe0, 0);
      chk("arst_addr", addr0, 0);
      chk("arst_result", res0, 0);
      key = word_of(1024 + 24);
      old = ref_w.exists(key) ? ref_w[key] : 32'h0;
      ref_w[key] = {old[31:16], 16'h5678};
      last_res[0] = 0; last_res[1] = 0;
      q.delete();
      w_en = 1'b0;
      #1;
      chk("arst_ready", rdy0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      issue(0, 1, 0, 1024 + 24, 32'h0);
      idle(2);

      // WAIT_CYCLES=1 instance: back-to-back load then store, then reload.
      issue(1, 0, 1, 1100, 32'hCAFE_F00D);
      idle(1);
      issue(1, 1, 0, 1100, 32'h0);
      issue(1, 0, 1, 1104, 32'h0BAD_0BAD);
      issue(1, 1, 0, 1100, 32'h0);
      idle(2);

      // Illegal both-enables at the wrap address is a store to the top word.
      issue(0, 1, 1, 1023, 32'hA5A5_5A5A);
      idle(1);
      issue(0, 1, 0, 1023, 32'h0);
      idle(2);

      for (int i = 0; i < 60; i++) begin
         a  = 1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) a = a + 32'(4 * Words);
         d  = $urandom;
         op = $urandom_range(0, 1) != 0;
         issue($urandom_range(0, 1) != 0, !op, op, a, d);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
